// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared SRAM.
// Optional burst lock re-grant is enabled with `define SRAM_ARB_LOCK_EN.
module sram_port_arbiter #(
   parameter int unsigned ADDR_W        = 8,
   parameter int unsigned DATA_W        = 16,
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              done0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              done1,
   output logic [DATA_W-1:0] rdata1,
`ifdef SRAM_ARB_LOCK_EN
   input  logic              lock0,
   input  logic              lock1,
`endif
   output logic [ADDR_W-1:0] sram_address,
   inout  wire  [DATA_W-1:0] sram_data,
   output logic              sram_chip_enable,
   output logic              sram_write_enable,
   output logic              sram_output_enable
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StRecover} state_e;

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic pick_valid;
   logic pick;
   logic owner_lock;
   logic busy;
   logic strobe;
   logic drive;

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      pick_valid = 1'b0;
      pick       = last_q;
`ifdef SRAM_ARB_LOCK_EN
      owner_lock = last_q ? (lock1 && req1) : (lock0 && req0);
`else
      owner_lock = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (req0 && req1) begin
               pick_valid = 1'b1;
               pick       = ~last_q;
            end else if (req0 || req1) begin
               pick_valid = 1'b1;
               pick       = req1;
            end
         end
         StSetup: begin
            state_d = StAccess;
            cnt_d   = 4'(ACCESS_CYCLES - 1);
         end
         StAccess: begin
            if (cnt_q == 4'd0) begin
               state_d = StRecover;
               if (!we_q) begin
                  if (last_q) rdata1_d = sram_data;
                  else        rdata0_d = sram_data;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StRecover: begin
            state_d = StIdle;
            // The port just served only gets straight back in under a burst lock.
            if (owner_lock) begin
               pick_valid = 1'b1;
               pick       = last_q;
            end else if (last_q ? req0 : req1) begin
               pick_valid = 1'b1;
               pick       = ~last_q;
            end
         end
         default: state_d = StIdle;
      endcase
      if (pick_valid) begin
         state_d = StSetup;
         last_d  = pick;
         we_d    = pick ? we1 : we0;
         addr_d  = pick ? addr1 : addr0;
         wdata_d = pick ? wdata1 : wdata0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         last_q   <= 1'b1;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= 4'd0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   // Strobes decode straight from registered state so reset clears them at once.
   always_comb begin
      busy               = (state_q != StIdle);
      strobe             = (state_q == StSetup) || (state_q == StAccess);
      drive              = busy && we_q;
      gnt0               = busy && !last_q;
      gnt1               = busy && last_q;
      done0              = (state_q == StRecover) && !last_q;
      done1              = (state_q == StRecover) && last_q;
      rdata0             = rdata0_q;
      rdata1             = rdata1_q;
      sram_address       = addr_q;
      sram_chip_enable   = !strobe;
      sram_write_enable  = !((state_q == StAccess) && we_q);
      sram_output_enable = !(strobe && !we_q);
   end

   assign sram_data = drive ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed timing checks, then randomized
// two-port traffic compared every cycle against a transaction-level model.
module tb_sram_port_arbiter;

   localparam int unsigned AC  = 2;
   localparam int          ACI = AC;
   localparam int          TXN = ACI + 2;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        req   [2];
   logic        we    [2];
   logic [7:0]  addr  [2];
   logic [15:0] wdata [2];
   logic        lock  [2];
   logic        gnt   [2];
   logic        done  [2];
   logic [15:0] rdata [2];
   logic [7:0]  sram_address;
   wire  [15:0] sram_data;
   logic        ce_n, we_n, oe_n;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(
      .ADDR_W        (8),
      .DATA_W        (16),
      .ACCESS_CYCLES (AC)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .req0               (req[0]),
      .we0                (we[0]),
      .addr0              (addr[0]),
      .wdata0             (wdata[0]),
      .gnt0               (gnt[0]),
      .done0              (done[0]),
      .rdata0             (rdata[0]),
      .req1               (req[1]),
      .we1                (we[1]),
      .addr1              (addr[1]),
      .wdata1             (wdata[1]),
      .gnt1               (gnt[1]),
      .done1              (done[1]),
      .rdata1             (rdata[1]),
`ifdef SRAM_ARB_LOCK_EN
      .lock0              (lock[0]),
      .lock1              (lock[1]),
`endif
      .sram_address       (sram_address),
      .sram_data          (sram_data),
      .sram_chip_enable   (ce_n),
      .sram_write_enable  (we_n),
      .sram_output_enable (oe_n)
   );

   // Asynchronous SRAM device
   logic [15:0] dev_mem [256];
   assign sram_data = (!ce_n && !oe_n) ? dev_mem[sram_address] : 'z;
   always @(posedge clk) if (!ce_n && !we_n) dev_mem[sram_address] <= sram_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: ph counts cycles since the arbitration edge (0 = idle).
   int          ph      = 0;
   int          m_owner = 1;
   bit          m_last  = 1'b1;
   bit          m_we    = 1'b0;
   logic [7:0]  m_addr  = 8'h00;
   logic [15:0] m_wdata = 16'h0000;
   logic [15:0] m_rd    [2];
   logic [15:0] ref_mem [256];

   always @(posedge clk or negedge reset) begin
      bit c0, c1;
      int win;
      if (!reset) begin
         ph      = 0;
         m_owner = 1;
         m_last  = 1'b1;
         m_rd[0] = 16'h0;
         m_rd[1] = 16'h0;
      end else begin
         win = -1;
         if (ph == ACI + 1) begin
            if (m_we) ref_mem[m_addr] = m_wdata;
            else      m_rd[m_owner] = ref_mem[m_addr];
         end
         if (ph == 0 || ph == TXN) begin
            c0 = req[0];
            c1 = req[1];
            if (ph == TXN) begin
`ifdef SRAM_ARB_LOCK_EN
               if (lock[m_owner] && req[m_owner]) win = m_owner;
`endif
               if (m_owner == 0) c0 = 1'b0;
               else              c1 = 1'b0;
            end
            if (win < 0) begin
               if (c0 && c1)  win = m_last ? 0 : 1;
               else if (c0)   win = 0;
               else if (c1)   win = 1;
            end
            if (win >= 0) begin
               m_owner = win;
               m_last  = (win == 1);
               m_we    = we[win];
               m_addr  = addr[win];
               m_wdata = wdata[win];
               ph      = 1;
            end else begin
               ph = 0;
            end
         end else begin
            ph++;
         end
      end
   end

   always @(negedge clk) begin
      bit strobe;
      if (reset) begin
         strobe = (ph >= 1) && (ph <= ACI + 1);
         for (int i = 0; i < 2; i++) begin
            chk(i == 0 ? "gnt0" : "gnt1", 32'(gnt[i]), 32'(ph != 0 && m_owner == i));
            chk(i == 0 ? "done0" : "done1", 32'(done[i]), 32'(ph == TXN && m_owner == i));
            chk(i == 0 ? "rdata0" : "rdata1", 32'(rdata[i]), 32'(m_rd[i]));
         end
         chk("gnt_both", 32'(gnt[0] && gnt[1]), 32'd0);
         chk("ce_n", 32'(ce_n), 32'(!strobe));
         chk("we_n", 32'(we_n), 32'(!(m_we && ph >= 2 && ph <= ACI + 1)));
         chk("oe_n", 32'(oe_n), 32'(!(!m_we && strobe)));
         if (ph != 0) chk("sram_address", 32'(sram_address), 32'(m_addr));
         if (ph != 0 && m_we) chk("wr_bus", 32'(sram_data), 32'(m_wdata));
      end
   end

   int dcyc  [2][2];
   int ndone [2];
   int gcnt  [2];
   int wcnt, ocnt;

   // Watch n cycles from the next SETUP; port i drops req after hold[i] done pulses.
   task automatic observe(input int n, input int hold0, input int hold1);
      int hold [2];
      hold[0] = hold0;
      hold[1] = hold1;
      wcnt = 0;
      ocnt = 0;
      for (int i = 0; i < 2; i++) begin
         dcyc[i][0] = 0;
         dcyc[i][1] = 0;
         ndone[i]   = 0;
         gcnt[i]    = 0;
      end
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (!we_n) wcnt++;
         if (!oe_n) ocnt++;
         for (int i = 0; i < 2; i++) begin
            if (gnt[i]) gcnt[i]++;
            if (done[i]) begin
               if (ndone[i] < 2) dcyc[i][ndone[i]] = k;
               ndone[i]++;
               if (ndone[i] >= hold[i]) req[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic set_port(input int i, input logic w, input logic [7:0] a, input logic [15:0] d);
      req[i]   = 1'b1;
      we[i]    = w;
      addr[i]  = a;
      wdata[i] = d;
   endtask

   task automatic new_params(input int i);
      we[i]    = 1'($urandom_range(0, 1));
      addr[i]  = 8'($urandom_range(0, 15));
      wdata[i] = 16'($urandom);
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin
         dev_mem[a] = 16'h0;
         ref_mem[a] = 16'h0;
      end
      m_rd[0] = 16'h0;
      m_rd[1] = 16'h0;
      for (int i = 0; i < 2; i++) begin
         req[i]   = 1'b0;
         we[i]    = 1'b0;
         addr[i]  = 8'h0;
         wdata[i] = 16'h0;
         lock[i]  = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_gnt0", 32'(gnt[0]), 32'd0);
      chk("rst_done1", 32'(done[1]), 32'd0);
      chk("rst_ce_n", 32'(ce_n), 32'd1);
      chk("rst_we_n", 32'(we_n), 32'd1);
      chk("rst_oe_n", 32'(oe_n), 32'd1);
      chk("rst_rdata0", 32'(rdata[0]), 32'd0);
      chk("rst_addr", 32'(sram_address), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Single write from port 0
      set_port(0, 1'b1, 8'h12, 16'hBEEF);
      observe(3 * TXN, 1, 1);
      chk("t1_gnt_cycles", 32'(gcnt[0]), 32'(TXN));
      chk("t1_we_cycles", 32'(wcnt), 32'(AC));
      chk("t1_done_cycle", 32'(dcyc[0][0]), 32'(TXN));
      chk("t1_mem", 32'(dev_mem[8'h12]), 32'hBEEF);

      // Port 1 reads it back
      set_port(1, 1'b0, 8'h12, 16'h0000);
      observe(3 * TXN, 1, 1);
      chk("t2_oe_cycles", 32'(ocnt), 32'(AC + 1));
      chk("t2_we_cycles", 32'(wcnt), 32'd0);
      chk("t2_done_cycle", 32'(dcyc[1][0]), 32'(TXN));
      chk("t2_rdata", 32'(rdata[1]), 32'hBEEF);
      repeat (5) @(negedge clk);
      chk("t2_rdata_held", 32'(rdata[1]), 32'hBEEF);

      // Simultaneous requests right after reset
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      set_port(0, 1'b1, 8'h03, 16'h3333);
      set_port(1, 1'b1, 8'h04, 16'h4444);
      observe(4 * TXN, 1, 1);
      chk("t3_done0", 32'(dcyc[0][0]), 32'(TXN));
      chk("t3_done1", 32'(dcyc[1][0]), 32'(2 * TXN));

      // Port 0 holds req across its done
      set_port(0, 1'b0, 8'h03, 16'h0000);
`ifdef SRAM_ARB_LOCK_EN
      lock[0] = 1'b1;
      set_port(1, 1'b0, 8'h04, 16'h0000);
      observe(5 * TXN, 2, 1);
      chk("t4_first0", 32'(dcyc[0][0]), 32'(TXN));
      chk("t4_second0", 32'(dcyc[0][1]), 32'(2 * TXN));
      chk("t4_done1", 32'(dcyc[1][0]), 32'(3 * TXN));
      lock[0] = 1'b0;
`else
      observe(5 * TXN, 2, 1);
      chk("t4_first0", 32'(dcyc[0][0]), 32'(TXN));
      chk("t4_second0", 32'(dcyc[0][1]), 32'(2 * TXN + 1));
`endif
      chk("t4_rdata0", 32'(rdata[0]), 32'h3333);

      // Reset in the middle of a write
      set_port(0, 1'b1, 8'h40, 16'h1234);
      @(negedge clk);
      @(negedge clk);
      chk("t5_in_access", 32'(we_n), 32'd0);
      #1;
      reset  = 1'b0;
      req[0] = 1'b0;
      #1;
      chk("t5_ce_n", 32'(ce_n), 32'd1);
      chk("t5_we_n", 32'(we_n), 32'd1);
      chk("t5_oe_n", 32'(oe_n), 32'd1);
      chk("t5_gnt0", 32'(gnt[0]), 32'd0);
      chk("t5_done0", 32'(done[0]), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      observe(3 * TXN, 1, 1);
      chk("t5_no_done", 32'(ndone[0]), 32'd0);
      chk("t5_mem", 32'(dev_mem[8'h40]), 32'd0);

      // Randomized two-port traffic
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #3;
         for (int i = 0; i < 2; i++) begin
            if (!req[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  req[i] = 1'b1;
                  new_params(i);
               end
            end else if (done[i]) begin
               if ($urandom_range(0, 1) == 0) new_params(i);
               else req[i] = 1'b0;
            end else if (gnt[i] && $urandom_range(0, 3) == 0) begin
               new_params(i);
            end
`ifdef SRAM_ARB_LOCK_EN
            lock[i] = ($urandom_range(0, 2) == 0);
`endif
         end
      end
      req[0]  = 1'b0;
      req[1]  = 1'b0;
      lock[0] = 1'b0;
      lock[1] = 1'b0;
      repeat (20) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Two-port arbiter and access sequencer for the shared 256x16 SRAM. It sits between the I2C slave front-end (port 0) and a second requester such as a host/debug port (port 1). It arbitrates round-robin and owns all SRAM strobes and the bidirectional data bus. It performs single-word reads and writes with fixed, parameterised timing.

Parameters:
ADDR_W, 8, SRAM address width
DATA_W, 16, SRAM data width
ACCESS_CYCLES, 2, cycles in ACCESS state (range 1..15)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
req0  input  1  port 0 request; hold high with stable we0/addr0/wdata0 until done0
we0  input  1  port 0 direction: 1 = write, 0 = read
addr0  input  ADDR_W  port 0 word address
wdata0  input  DATA_W  port 0 write data
gnt0  output  1  port 0 owns SRAM (SETUP through RECOVER)
done0  output  1  one-cycle completion pulse for port 0
rdata0  output  DATA_W  port 0 read data; valid from done0, held until the next port-0 read completes
req1, we1, addr1, wdata1, gnt1, done1, rdata1  same as port 0, for port 1
lock0, lock1  input  1  burst lock (only with SRAM_ARB_LOCK_EN)
sram_address  output  ADDR_W  SRAM address
sram_data  inout  DATA_W  SRAM data bus; high-Z when not driven
sram_chip_enable  output  1  active-low chip enable
sram_write_enable  output  1  active-low write enable
sram_output_enable  output  1  active-low output enable

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; gnt*/done* = 0; rdata* = 0; sram_address = 0.
  - sram_chip_enable, sram_write_enable, sram_output_enable = 1; sram_data = Z.
  - last_served = 1, so port 0 wins the first tie.
- Reset mid-transaction: the access is abandoned, no done pulse, strobes deassert at once. A requester must reissue after reset releases.
- States: IDLE -> SETUP -> ACCESS (ACCESS_CYCLES cycles, down-counter) -> RECOVER -> IDLE or SETUP.
- Arbitration (in IDLE and RECOVER):
  - Only one requester: it wins.
  - Both requesting: the port != last_served wins.
  - In RECOVER, the port just served is excluded, so a back-to-back access from the same port passes through one IDLE cycle.
  - Winner's addr/we/wdata are latched at the arbitration edge; last_served is updated.
- SETUP (1 cycle):
  - sram_address = latched address; chip_enable = 0.
  - Write: drive sram_data = latched wdata.
  - Read: output_enable = 0.
- ACCESS:
  - Write: write_enable = 0, data driven.
  - Read: output_enable = 0. sram_data is captured into the owner's rdata on the clock edge that ends the last ACCESS cycle.
- RECOVER (1 cycle):
  - write_enable = 1, output_enable = 1, chip_enable = 1.
  - Write data stays driven through RECOVER (hold time), then goes Z.
  - done of the owner = 1.
- gnt of the owner is high during SETUP, ACCESS and RECOVER; at most one gnt is high at a time.
- Latency, arbitration edge to done: 2 + ACCESS_CYCLES cycles (default 4). Idle throughput with both ports busy: one access per 3 + ACCESS_CYCLES - 1 cycles, because RECOVER arbitrates directly into SETUP.
- Address and data pass through unmodified; there is no wrap or increment logic. Sequencing of address + 1 is the requester's job.
- Changing req/we/addr/wdata while granted has no effect on the latched transaction.

Optional Feature:
SRAM_ARB_LOCK_EN
- Defined: lock0/lock1 ports exist. If the owner's lock is high in RECOVER and its req is high, the same port is re-granted straight into SETUP with no IDLE cycle, and the other port waits. The lock is ignored in IDLE arbitration.
- Undefined: lock ports are absent; strict round-robin as above.

Test Plan:
1. Port 0 write, addr 0x12, data 0xBEEF, with req1 = 0 -> gnt0 high 4 cycles; WE low exactly 2 cycles; done0 at cycle 4; SRAM[0x12] = 0xBEEF.
2. Port 1 read of 0x12 after test 1 -> OE low 3 cycles (SETUP + ACCESS); rdata1 = 0xBEEF at done1 and held; sram_data Z throughout.
3. req0 and req1 both raised on the same edge after reset -> port 0 served first, port 1 enters SETUP directly from RECOVER; done pulses 4 cycles apart; gnt0 and gnt1 never both high.
4. Port 0 holds req0 across done0 while req1 = 0 -> one IDLE cycle, then a second port-0 access; with SRAM_ARB_LOCK_EN and lock0 = 1 -> no IDLE cycle and port 1 is blocked until lock0 drops.
5. Assert reset during ACCESS of a write -> all strobes go to 1 and sram_data goes Z in the same cycle; no done pulse; state = IDLE after release.
6. ACCESS_CYCLES = 5 -> WE low 5 cycles; done at cycle 7.
